// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Synchronizes and debounces raw board push buttons and slide
//                switches before they reach the SoC PIO ports.
//                Each bit passes through a 2-flop synchronizer and then a
//                per-bit debounce counter. The block also produces a one-cycle
//                key-press pulse, sticky key-event flags (write-one-to-clear)
//                and a one-cycle pulse when any debounced switch changes.
//  Ports       : Clk, Reset             - clock, synchronous active-high reset
//                KEY_N, SW_RAW          - raw asynchronous pin inputs
//                key_db, sw_db          - debounced levels (keys stay active-low)
//                key_press              - pulse on debounced key press (1->0)
//                key_event, event_clr   - sticky press flags, W1C clear
//                sw_change              - pulse when any sw_db bit changes
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] KEY_N,
    input  logic [N_SW-1:0]   SW_RAW,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_SW-1:0]   sw_db,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_event,
    input  logic [N_KEYS-1:0] event_clr,
    output logic              sw_change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int N_ALL = N_KEYS + N_SW;

    localparam logic [CNT_W-1:0] c_term_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Keys idle high (active-low buttons), switches idle low.
    localparam logic [N_ALL-1:0] c_rst_val  = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

    // Keys occupy the low bits, switches the high bits of the combined vector.
    logic [N_ALL-1:0] w_raw;
    logic [N_ALL-1:0] r_s1;
    logic [N_ALL-1:0] r_s2;
    logic [N_ALL-1:0] w_db;
    logic [N_ALL-1:0] w_upd;

    logic [N_KEYS-1:0] r_key_press;
    logic [N_KEYS-1:0] r_key_event;
    logic              r_sw_change;
    logic [N_KEYS-1:0] w_press;

    assign w_raw = {SW_RAW, KEY_N};

    // Two-flop synchronizer; only r_s2 is used downstream.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1 <= c_rst_val;
            r_s2 <= c_rst_val;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce: the counter runs only while the synchronized input
    // disagrees with the accepted level; any agreement restarts it.
    for (genvar gi = 0; gi < N_ALL; gi++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;

        assign w_db[gi]  = r_db;
        assign w_upd[gi] = (r_s2[gi] != r_db) && (r_cnt == c_term_cnt);

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cnt <= '0;
                r_db  <= c_rst_val[gi];
            end else if (r_s2[gi] != r_db) begin
                if (r_cnt == c_term_cnt) begin
                    r_db  <= r_s2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // An accepted update towards 0 on a key bit is a press; registering it
    // alongside r_db makes the pulse coincide with key_db first reading 0.
    assign w_press = w_upd[N_KEYS-1:0] & ~r_s2[N_KEYS-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_press <= '0;
            r_key_event <= '0;
            r_sw_change <= 1'b0;
        end else begin
            r_key_press <= w_press;
            // Set term is ORed after the clear so a coincident set wins.
            r_key_event <= (r_key_event & ~event_clr) | r_key_press;
            r_sw_change <= |w_upd[N_ALL-1:N_KEYS];
        end
    end

    assign key_db    = w_db[N_KEYS-1:0];
    assign sw_db     = w_db[N_ALL-1:N_KEYS];
    assign key_press = r_key_press;
    assign key_event = r_key_event;
    assign sw_change = r_sw_change;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_conditioner
//  Description : Scoreboard bench for input_conditioner (DEBOUNCE_CYCLES=4).
//                Stimulus pushes expected output snapshots tagged with the
//                clock edge at which they must appear; a monitor pops one
//                entry whenever any DUT output changes and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] key_n;
    logic [7:0] sw_raw;
    logic [1:0] event_clr;
    logic [1:0] key_db;
    logic [7:0] sw_db;
    logic [1:0] key_press;
    logic [1:0] key_event;
    logic       sw_change;

    input_conditioner #(
        .N_KEYS          (2),
        .N_SW            (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .KEY_N     (key_n),
        .SW_RAW    (sw_raw),
        .key_db    (key_db),
        .sw_db     (sw_db),
        .key_press (key_press),
        .key_event (key_event),
        .event_clr (event_clr),
        .sw_change (sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after a posedge it holds the number of edges seen.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [14:0] snap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Snapshot layout: {key_db, sw_db, key_press, key_event, sw_change}
    task automatic expect_at(input int d, input logic [1:0] kdb, input logic [7:0] sw,
                             input logic [1:0] pr, input logic [1:0] ev, input logic chg);
        exp_t e;
        e.cyc  = 32'(cyc + d);
        e.snap = {kdb, sw, pr, ev, chg};
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output change must match the next queued expectation.
    logic [14:0] prev_snap = '0;
    always @(negedge clk) begin
        logic [14:0] cur;
        exp_t        e;
        cur = {key_db, sw_db, key_press, key_event, sw_change};
        if (mon_en && (cur !== prev_snap)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: edge %0d got 0x%0h required unchanged 0x%0h",
                         cyc, cur, prev_snap);
            end else begin
                e = exp_q.pop_front();
                check("event_edge", 32'(cyc), e.cyc);
                check("event_value", {17'd0, cur}, {17'd0, e.snap});
            end
        end
        prev_snap = cur;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test, required end within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        key_n     = 2'b11;
        sw_raw    = 8'h00;
        event_clr = 2'b00;
        step(3);
        check("reset_key_db",    {30'd0, key_db},    32'h3);
        check("reset_sw_db",     {24'd0, sw_db},     32'h0);
        check("reset_key_press", {30'd0, key_press}, 32'h0);
        check("reset_key_event", {30'd0, key_event}, 32'h0);
        check("reset_sw_change", {31'd0, sw_change}, 32'h0);
        rst = 1'b0;
        step(3);
        mon_en = 1'b1;

        // Clean press of key 0: db on 6th edge, event one edge later.
        key_n = 2'b10;
        expect_at(6, 2'b10, 8'h00, 2'b01, 2'b00, 1'b0);
        expect_at(7, 2'b10, 8'h00, 2'b00, 2'b01, 1'b0);
        step(12);

        // Bounce on key 1: 2-cycle pulses never reach the terminal count.
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0;
            step(2);
            key_n[1] = 1'b1;
            step(2);
        end
        step(10);
        check("bounce_key_db1", {31'd0, key_db[1]}, 32'h1);

        // Release of key 0: level follows, no pulse, event stays set.
        key_n = 2'b11;
        expect_at(6, 2'b11, 8'h00, 2'b00, 2'b01, 1'b0);
        step(12);

        // Clear pending event.
        event_clr = 2'b01;
        expect_at(1, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
        step(1);
        event_clr = 2'b00;
        step(3);

        // Clear with nothing pending: no output change.
        event_clr = 2'b10;
        step(1);
        event_clr = 2'b00;
        step(3);

        // Set/clear race: clear lands on the edge the flag sets; set wins.
        key_n = 2'b10;
        expect_at(6, 2'b10, 8'h00, 2'b01, 2'b00, 1'b0);
        expect_at(7, 2'b10, 8'h00, 2'b00, 2'b01, 1'b0);
        step(6);
        event_clr = 2'b01;
        step(1);
        event_clr = 2'b00;
        step(6);

        // Multi-bit switch change gives one pulse, then a single-bit flip.
        sw_raw = 8'hA5;
        expect_at(6, 2'b10, 8'hA5, 2'b00, 2'b01, 1'b1);
        expect_at(7, 2'b10, 8'hA5, 2'b00, 2'b01, 1'b0);
        step(12);
        sw_raw = 8'hA4;
        expect_at(6, 2'b10, 8'hA4, 2'b00, 2'b01, 1'b1);
        expect_at(7, 2'b10, 8'hA4, 2'b00, 2'b01, 1'b0);
        step(12);

        // Release key 0 so the mid-count reset scenario starts from idle.
        key_n = 2'b11;
        expect_at(6, 2'b11, 8'hA4, 2'b00, 2'b01, 1'b0);
        step(12);

        // Reset mid-count; switches held at 0xA4 through reset must
        // reappear with a sw_change pulse alongside the restarted key press.
        key_n = 2'b10;
        step(3);
        rst = 1'b1;
        expect_at(1, 2'b11, 8'h00, 2'b00, 2'b00, 1'b0);
        step(1);
        rst = 1'b0;
        expect_at(6, 2'b10, 8'hA4, 2'b01, 2'b00, 1'b1);
        expect_at(7, 2'b10, 8'hA4, 2'b00, 2'b01, 1'b0);
        step(12);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
